dbg_ctrl: RTL and testbench

Host-facing debug run-control block. It accepts debug commands from the simulation host: halt, resume, single-step, GPR/PC read/write. It sequences the core's halt request against pipeline drain and returns one response per command. It sits between the host command channel and the core's IFU stall, GPR debug port and PC override, and consumes the same commit signals the commit-trace monitor reports.

---
 rtl/dbg_pkg.sv | 49 ++++
 rtl/dbg_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_dbg_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug run-control block.
package dbg_pkg;

   // Host command opcodes
   typedef enum logic [2:0] {
      OP_STATUS = 3'd0,
      OP_HALT   = 3'd1,
      OP_RESUME = 3'd2,
      OP_STEP   = 3'd3,
      OP_RD_GPR = 3'd4,
      OP_WR_GPR = 3'd5,
      OP_RD_PC  = 3'd6,
      OP_WR_PC  = 3'd7
   } dbg_op_e;

   // Reason the core last entered the halted state
   typedef enum logic [1:0] {
      CAUSE_HOST    = 2'd0,
      CAUSE_STEP    = 2'd1,
      CAUSE_EBREAK  = 2'd2,
      CAUSE_ILLEGAL = 2'd3
   } halt_cause_e;

   // Run-control FSM states
   typedef enum logic [2:0] {
      ST_RUN        = 3'd0,
      ST_DRAIN      = 3'd1,
      ST_HALTED     = 3'd2,
      ST_STEP_RUN   = 3'd3,
      ST_STEP_DRAIN = 3'd4,
      ST_RESP       = 3'd5
   } dbg_state_e;

   // STATUS response layout
   localparam int unsigned STAT_CAUSE_LSB  = 0;
   localparam int unsigned STAT_CAUSE_W    = 2;
   localparam int unsigned STAT_HALTED_BIT = 2;

   // Halt cause implied by a retiring instruction's exception flags
   function automatic halt_cause_e commit_cause(input logic brk, input logic ivd,
                                                input halt_cause_e dflt);
      if (brk)
         return CAUSE_EBREAK;
      if (ivd)
         return CAUSE_ILLEGAL;
      return dflt;
   endfunction

endpackage

// File: rtl/dbg_ctrl.sv
// Debug run-control: host command decode, halt/step sequencing against
// pipeline drain, GPR/PC access while halted, one response per command.
module dbg_ctrl
   import dbg_pkg::*;
#(
   parameter int unsigned XLEN          = 32,
   parameter int unsigned GPR_NUM       = 16,
   parameter bit          HALT_ON_RESET = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [2:0]      cmd_op,
   input  logic [4:0]      cmd_addr,
   input  logic [XLEN-1:0] cmd_data,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_data,
   output logic            rsp_err,
   output logic            core_halt_req,
   input  logic            core_idle,
   input  logic            commit_done,
   input  logic [XLEN-1:0] commit_pc,
   input  logic            commit_brk,
   input  logic            commit_ivd,
   output logic [4:0]      gpr_raddr,
   input  logic [XLEN-1:0] gpr_rdata,
   output logic            gpr_wen,
   output logic [4:0]      gpr_waddr,
   output logic [XLEN-1:0] gpr_wdata,
   output logic            pc_wen,
   output logic [XLEN-1:0] pc_wdata,
   output logic            halted,
   output logic [1:0]      halt_cause
);

   dbg_state_e      state;
   logic            pend_halt;
   logic [XLEN-1:0] last_pc;
   logic [XLEN-1:0] step_pc;
   logic [XLEN-1:0] pc_now;
   logic [XLEN-1:0] status_word;
   logic            accept;
   logic            addr_ok;
   logic            brk_commit;
   dbg_op_e         op;

   assign accept     = cmd_valid && cmd_ready;
   assign op         = dbg_op_e'(cmd_op);
   assign addr_ok    = 32'(cmd_addr) < 32'(GPR_NUM);
   assign brk_commit = commit_done && (commit_brk || commit_ivd);
   // last_pc including a retirement landing in the current cycle
   assign pc_now     = commit_done ? commit_pc : last_pc;
   // core answers reads combinationally, so the index is only driven while a read is accepted
   assign gpr_raddr  = (accept && state == ST_HALTED && op == OP_RD_GPR) ? cmd_addr : 5'd0;

   // STATUS word: halted flag above the current halt cause
   always_comb begin
      status_word = '0;
      status_word[STAT_CAUSE_LSB +: STAT_CAUSE_W] = halt_cause;
      status_word[STAT_HALTED_BIT] = halted;
   end

   // Run-control FSM with registered handshake, core-control and response outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= HALT_ON_RESET ? ST_HALTED : ST_RUN;
         core_halt_req <= HALT_ON_RESET;
         halted        <= HALT_ON_RESET;
         halt_cause    <= CAUSE_HOST;
         cmd_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         rsp_err       <= 1'b0;
         gpr_wen       <= 1'b0;
         gpr_waddr     <= 5'd0;
         gpr_wdata     <= '0;
         pc_wen        <= 1'b0;
         pc_wdata      <= '0;
         pend_halt     <= 1'b0;
         last_pc       <= '0;
         step_pc       <= '0;
      end else begin
         gpr_wen <= 1'b0;
         pc_wen  <= 1'b0;
         if (commit_done)
            last_pc <= commit_pc;

         if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            cmd_ready <= (state == ST_RUN) || (state == ST_HALTED);
         end

         // Default for an accepted command is an immediate ok response; HALT/STEP defer it
         if (accept) begin
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b0;
         end

         case (state)
            ST_RUN: begin
               if (accept) begin
                  case (op)
                     OP_STATUS: rsp_data <= status_word;
                     OP_HALT: begin
                        rsp_valid     <= 1'b0;
                        pend_halt     <= 1'b1;
                        core_halt_req <= 1'b1;
                        halt_cause    <= CAUSE_HOST;
                        state         <= ST_DRAIN;
                     end
                     OP_RESUME: rsp_err <= 1'b0;
                     default:   rsp_err <= 1'b1;
                  endcase
               end
               // A trapping retirement wins the cause over a simultaneous host HALT
               if (brk_commit) begin
                  core_halt_req <= 1'b1;
                  halt_cause    <= commit_cause(commit_brk, commit_ivd, CAUSE_HOST);
                  state         <= ST_DRAIN;
                  cmd_ready     <= 1'b0;
               end
            end

            ST_DRAIN: begin
               if (core_idle) begin
                  state  <= ST_HALTED;
                  halted <= 1'b1;
                  if (pend_halt) begin
                     pend_halt <= 1'b0;
                     rsp_valid <= 1'b1;
                     rsp_data  <= pc_now;
                     rsp_err   <= 1'b0;
                     cmd_ready <= 1'b0;
                  end else begin
                     cmd_ready <= !rsp_valid || rsp_ready;
                  end
               end
            end

            ST_HALTED: begin
               if (accept) begin
                  case (op)
                     OP_STATUS: rsp_data <= status_word;
                     OP_HALT:   rsp_err  <= 1'b0;
                     OP_RESUME: begin
                        core_halt_req <= 1'b0;
                        halted        <= 1'b0;
                        state         <= ST_RUN;
                     end
                     OP_STEP: begin
                        rsp_valid     <= 1'b0;
                        core_halt_req <= 1'b0;
                        halted        <= 1'b0;
                        state         <= ST_STEP_RUN;
                     end
                     OP_RD_GPR: begin
                        if (addr_ok)
                           rsp_data <= gpr_rdata;
                        else
                           rsp_err <= 1'b1;
                     end
                     OP_WR_GPR: begin
                        if (!addr_ok) begin
                           rsp_err <= 1'b1;
                        end else if (cmd_addr != 5'd0) begin
                           gpr_wen   <= 1'b1;
                           gpr_waddr <= cmd_addr;
                           gpr_wdata <= cmd_data;
                        end
                     end
                     OP_RD_PC: rsp_data <= last_pc;
                     OP_WR_PC: begin
                        pc_wen   <= 1'b1;
                        pc_wdata <= cmd_data;
                        last_pc  <= cmd_data;
                     end
                  endcase
               end
            end

            ST_STEP_RUN: begin
               // Only the first retirement is the stepped instruction
               if (commit_done) begin
                  core_halt_req <= 1'b1;
                  step_pc       <= commit_pc;
                  halt_cause    <= commit_cause(commit_brk, commit_ivd, CAUSE_STEP);
                  if (core_idle) begin
                     state     <= ST_HALTED;
                     halted    <= 1'b1;
                     rsp_valid <= 1'b1;
                     rsp_data  <= commit_pc;
                     rsp_err   <= 1'b0;
                  end else begin
                     state <= ST_STEP_DRAIN;
                  end
               end
            end

            ST_STEP_DRAIN: begin
               if (core_idle) begin
                  state     <= ST_HALTED;
                  halted    <= 1'b1;
                  rsp_valid <= 1'b1;
                  rsp_data  <= step_pc;
                  rsp_err   <= 1'b0;
               end
            end

            default: begin
               state         <= ST_RUN;
               halted        <= 1'b0;
               core_halt_req <= 1'b0;
               cmd_ready     <= !rsp_valid;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dbg_ctrl.sv
// Randomized bench for dbg_ctrl against a transaction-level debug model.
module tb_dbg_ctrl;
   import dbg_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [4:0]  cmd_addr;
   logic [31:0] cmd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        core_halt_req;
   logic        core_idle;
   logic        commit_done;
   logic [31:0] commit_pc;
   logic        commit_brk;
   logic        commit_ivd;
   logic [4:0]  gpr_raddr;
   logic [31:0] gpr_rdata;
   logic        gpr_wen;
   logic [4:0]  gpr_waddr;
   logic [31:0] gpr_wdata;
   logic        pc_wen;
   logic [31:0] pc_wdata;
   logic        halted;
   logic [1:0]  halt_cause;

   // core-side register file as seen through the debug port
   logic [31:0] core_regs [32];
   int          gpr_pulses;
   int          pc_pulses;
   logic [31:0] last_pc_wdata;

   // reference model of the architectural debug view
   bit          m_halted;
   logic [1:0]  m_cause;
   logic [31:0] m_last_pc;
   logic [31:0] m_gpr [16];
   logic [31:0] pc_gen;

   int          n_pass;
   int          n_chk;

   always #5 clk = ~clk;

   assign gpr_rdata = core_regs[gpr_raddr];

   dbg_ctrl #(.XLEN(32), .GPR_NUM(16), .HALT_ON_RESET(1'b0)) u_dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .core_halt_req(core_halt_req), .core_idle(core_idle),
      .commit_done(commit_done), .commit_pc(commit_pc),
      .commit_brk(commit_brk), .commit_ivd(commit_ivd),
      .gpr_raddr(gpr_raddr), .gpr_rdata(gpr_rdata),
      .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
      .pc_wen(pc_wen), .pc_wdata(pc_wdata),
      .halted(halted), .halt_cause(halt_cause)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
   endtask

   // advance one clock and act as the core sampling the write ports
   task automatic cyc();
      @(posedge clk);
      #1;
      if (gpr_wen) begin
         core_regs[gpr_waddr] = gpr_wdata;
         gpr_pulses++;
      end
      if (pc_wen) begin
         pc_pulses++;
         last_pc_wdata = pc_wdata;
      end
   endtask

   task automatic do_commit(input logic [31:0] pc, input logic brk, input logic ivd, input logic idle);
      commit_done = 1'b1;
      commit_pc   = pc;
      commit_brk  = brk;
      commit_ivd  = ivd;
      core_idle   = idle;
      cyc();
      commit_done = 1'b0;
      commit_brk  = 1'b0;
      commit_ivd  = 1'b0;
      m_last_pc   = pc;
   endtask

   task automatic run_commits(input int unsigned k);
      for (int i = 0; i < int'(k); i++) begin
         pc_gen = pc_gen + 32'd4;
         do_commit(pc_gen, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic send_cmd(input dbg_op_e op, input logic [4:0] addr, input logic [31:0] data);
      int n = 0;
      while (!cmd_ready && n < 64) begin
         cyc();
         n++;
      end
      if (!cmd_ready)
         chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_data  = data;
      cyc();
      cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(input string tag, input logic [31:0] exp_data, input logic exp_err,
                          input int unsigned hold);
      int n = 0;
      bit stable = 1'b1;
      logic [31:0] d0;
      logic e0;
      while (!rsp_valid && n < 64) begin
         cyc();
         n++;
      end
      chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      d0 = rsp_data;
      e0 = rsp_err;
      if (cmd_ready)
         stable = 1'b0;
      for (int i = 0; i < int'(hold); i++) begin
         cyc();
         if (!rsp_valid || rsp_data !== d0 || rsp_err !== e0 || cmd_ready)
            stable = 1'b0;
      end
      chk({tag, "_data"}, rsp_data, exp_data);
      chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
      chk({tag, "_stable"}, 32'(stable), 32'd1);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      chk({tag, "_clr"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
   endtask

   task automatic imm(input dbg_op_e op, input string tag, input logic [31:0] exp_data,
                      input logic exp_err, input int unsigned hold);
      send_cmd(op, 5'd0, 32'd0);
      get_rsp(tag, exp_data, exp_err, hold);
   endtask

   task automatic do_halt(input int unsigned ndrain, input bit brk_same, input int unsigned idle_dly,
                          input int unsigned hold);
      if (brk_same) begin
         pc_gen      = pc_gen + 32'd4;
         commit_done = 1'b1;
         commit_pc   = pc_gen;
         commit_brk  = 1'b1;
         m_last_pc   = pc_gen;
      end
      send_cmd(OP_HALT, 5'd0, 32'd0);
      commit_done = 1'b0;
      commit_brk  = 1'b0;
      chk("halt_hreq", 32'(core_halt_req), 32'd1);
      run_commits(ndrain);
      repeat (idle_dly) cyc();
      core_idle = 1'b1;
      get_rsp("halt", m_last_pc, 1'b0, hold);
      m_halted = 1'b1;
      m_cause  = brk_same ? CAUSE_EBREAK : CAUSE_HOST;
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_cause", 32'(halt_cause), 32'(m_cause));
   endtask

   task automatic auto_halt(input bit brk);
      int n = 0;
      pc_gen = pc_gen + 32'd4;
      do_commit(pc_gen, brk, !brk, 1'b0);
      chk("trap_hreq", 32'(core_halt_req), 32'd1);
      repeat ($urandom_range(0, 3)) cyc();
      core_idle = 1'b1;
      while (!halted && n < 16) begin
         cyc();
         n++;
      end
      m_halted = 1'b1;
      m_cause  = brk ? CAUSE_EBREAK : CAUSE_ILLEGAL;
      chk("trap_halted", 32'(halted), 32'd1);
      chk("trap_cause", 32'(halt_cause), 32'(m_cause));
      chk("trap_no_rsp", 32'(rsp_valid), 32'd0);
   endtask

   task automatic do_step(input int unsigned flag, input bit direct, input bit second,
                          input int unsigned hold);
      logic [31:0] a;
      send_cmd(OP_STEP, 5'd0, 32'd0);
      core_idle = 1'b0;
      chk("step_release", 32'(core_halt_req), 32'd0);
      repeat ($urandom_range(0, 2)) cyc();
      pc_gen = pc_gen + 32'd4;
      a = pc_gen;
      do_commit(a, flag == 1, flag == 2, direct);
      chk("step_hreq", 32'(core_halt_req), 32'd1);
      if (direct) begin
         chk("step_direct", 32'(halted), 32'd1);
      end else begin
         if (second) begin
            pc_gen = pc_gen + 32'd4;
            do_commit(pc_gen, 1'b0, 1'b0, 1'b0);
         end
         repeat ($urandom_range(0, 2)) cyc();
         core_idle = 1'b1;
      end
      get_rsp("step", a, 1'b0, hold);
      m_halted = 1'b1;
      m_cause  = (flag == 1) ? CAUSE_EBREAK : (flag == 2) ? CAUSE_ILLEGAL : CAUSE_STEP;
      chk("step_halted", 32'(halted), 32'd1);
      chk("step_cause", 32'(halt_cause), 32'(m_cause));
   endtask

   task automatic do_resume(input int unsigned hold);
      imm(OP_RESUME, "resume", 32'd0, 1'b0, hold);
      m_halted  = 1'b0;
      core_idle = 1'b0;
      chk("resume_halted", 32'(halted), 32'd0);
      chk("resume_hreq", 32'(core_halt_req), 32'd0);
   endtask

   task automatic do_reg(input dbg_op_e op, input logic [4:0] addr, input logic [31:0] data,
                         input int unsigned hold);
      logic [31:0] exp_data = 32'd0;
      logic        exp_err  = 1'b0;
      int          exp_gp   = 0;
      int          exp_pcp  = 0;
      int          g0       = gpr_pulses;
      int          p0       = pc_pulses;
      bit          ok       = addr < 5'd16;
      case (op)
         OP_RD_GPR: if (!m_halted || !ok) exp_err = 1'b1; else exp_data = m_gpr[addr[3:0]];
         OP_WR_GPR: begin
            if (!m_halted || !ok) exp_err = 1'b1;
            else if (addr != 5'd0) begin
               exp_gp = 1;
               m_gpr[addr[3:0]] = data;
            end
         end
         OP_RD_PC: if (!m_halted) exp_err = 1'b1; else exp_data = m_last_pc;
         default: begin
            if (!m_halted) exp_err = 1'b1;
            else begin
               exp_pcp   = 1;
               m_last_pc = data;
            end
         end
      endcase
      send_cmd(op, addr, data);
      get_rsp("reg", exp_data, exp_err, hold);
      chk("reg_gpr_pulses", 32'(gpr_pulses - g0), 32'(exp_gp));
      chk("reg_pc_pulses", 32'(pc_pulses - p0), 32'(exp_pcp));
      if (exp_gp != 0)
         chk("reg_gpr_written", core_regs[addr], data);
      if (exp_pcp != 0)
         chk("reg_pc_wdata", last_pc_wdata, data);
   endtask

   function automatic logic [31:0] exp_status();
      return {29'd0, m_halted, m_cause};
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      dbg_op_e     op;
      logic [4:0]  addr;
      int unsigned hold;
      int unsigned r;

      n_pass = 0; n_chk = 0; gpr_pulses = 0; pc_pulses = 0; last_pc_wdata = 32'd0;
      reset = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 5'd0; cmd_data = 32'd0;
      rsp_ready = 1'b0; core_idle = 1'b0; commit_done = 1'b0; commit_pc = 32'd0;
      commit_brk = 1'b0; commit_ivd = 1'b0;
      for (int i = 0; i < 32; i++)
         core_regs[i] = (i == 0) ? 32'd0 : (32'hA500_0000 | 32'(i));
      for (int i = 0; i < 16; i++)
         m_gpr[i] = core_regs[i];
      m_halted = 1'b0; m_cause = CAUSE_HOST; m_last_pc = 32'd0; pc_gen = 32'h8000_0000;

      // reset state and first STATUS
      repeat (3) cyc();
      reset = 1'b1;
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_hreq", 32'(core_halt_req), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_wen", 32'({gpr_wen, pc_wen}), 32'd0);
      imm(OP_STATUS, "status0", exp_status(), 1'b0, 0);

      // host halt, idle 5 cycles after a commit at 0x80000010
      pc_gen = 32'h8000_000C;
      run_commits(1);
      do_halt(0, 1'b0, 5, 0);

      // register access while halted
      do_reg(OP_WR_GPR, 5'd5, 32'hDEAD_BEEF, 0);
      do_reg(OP_RD_GPR, 5'd5, 32'd0, 0);
      do_reg(OP_WR_GPR, 5'd0, 32'h1234_5678, 0);
      do_reg(OP_RD_GPR, 5'd20, 32'd0, 0);

      // single step with two commits
      pc_gen = 32'h7FFF_FFFC;
      do_step(0, 1'b0, 1'b1, 0);

      // ebreak retirement while running
      do_resume(0);
      pc_gen = 32'h8000_001C;
      auto_halt(1'b1);
      do_reg(OP_RD_PC, 5'd0, 32'd0, 0);

      // register read while running, response held 3 cycles
      do_resume(0);
      do_reg(OP_RD_GPR, 5'd3, 32'd0, 3);

      // reset during drain aborts the pending halt
      send_cmd(OP_HALT, 5'd0, 32'd0);
      chk("drain_hreq", 32'(core_halt_req), 32'd1);
      cyc();
      reset = 1'b0;
      repeat (2) cyc();
      reset = 1'b1;
      chk("mid_rst_halted", 32'(halted), 32'd0);
      chk("mid_rst_hreq", 32'(core_halt_req), 32'd0);
      chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
      chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
      core_idle = 1'b1;
      repeat (3) cyc();
      chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
      core_idle = 1'b0;
      m_halted = 1'b0; m_cause = CAUSE_HOST; m_last_pc = 32'd0;
      imm(OP_STATUS, "status_rst", exp_status(), 1'b0, 0);

      // randomized command stream
      for (int it = 0; it < 80; it++) begin
         if (!m_halted) begin
            run_commits($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0)
               auto_halt(1'($urandom_range(0, 1)));
         end
         op   = dbg_op_e'(3'($urandom_range(0, 7)));
         addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(0, 31));
         hold = $urandom_range(0, 3);
         case (op)
            OP_STATUS: imm(OP_STATUS, "status", exp_status(), 1'b0, hold);
            OP_HALT: begin
               if (m_halted)
                  imm(OP_HALT, "halt_again", 32'd0, 1'b0, hold);
               else
                  do_halt($urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom_range(0, 3), hold);
            end
            OP_RESUME: begin
               if (m_halted)
                  do_resume(hold);
               else
                  imm(OP_RESUME, "resume_run", 32'd0, 1'b0, hold);
            end
            OP_STEP: begin
               if (m_halted) begin
                  r = $urandom_range(0, 3);
                  do_step((r == 3) ? 2 : (r == 2) ? 1 : 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 1) == 1, hold);
               end else begin
                  imm(OP_STEP, "step_run", 32'd0, 1'b1, hold);
               end
            end
            default: do_reg(op, addr, $urandom, hold);
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
